// File: rtl/subtractor_pkg.sv
// subtractor_pkg: shared state type and sizing helper for the bit-serial subtractor
package subtractor_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t;
  localparam int DEF_N = 32;
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/subtractor_1.sv
// subtractor_1: combinational single-bit full subtractor
module subtractor_1 (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);
  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/subtractor_serial.sv
// subtractor_serial: computes a - b - b_in one bit per clock, LSB first, through one full-subtractor cell
module subtractor_serial
  import subtractor_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic [N-1:0] diff,
  output logic         b_out,
  output logic         overflow,
  output logic         zero,
  output logic         done
);
  localparam int CW = cnt_width(N);
  sub_state_t state, state_n;
  logic [N-1:0] a_sr, b_sr, d_sr;
  logic [CW-1:0] cnt;
  logic borrow, a_msb, b_msb, d_bit, bo_bit, last;
  assign last  = cnt == CW'(N - 1);
  assign ready = state == IDLE;
  assign diff  = d_sr;
  assign b_out = borrow;
  subtractor_1 u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .b_in (borrow),
    .diff (d_bit),
    .b_out(bo_bit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? BUSY :
              (state == BUSY && last)  ? DONE :
              (state == DONE)          ? IDLE : state;
  end
  // Flags are latched on the final bit edge so they hold through IDLE with the result.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= state == BUSY && last;
      if (state == IDLE && start) begin
        a_sr   <= a;
        b_sr   <= b;
        borrow <= b_in;
        cnt    <= '0;
        a_msb  <= a[N-1];
        b_msb  <= b[N-1];
      end else if (state == BUSY) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        d_sr   <= {d_bit, d_sr[N-1:1]};
        borrow <= bo_bit;
        cnt    <= cnt + CW'(1);
        if (last) begin
          zero     <= {d_bit, d_sr[N-1:1]} == '0;
          overflow <= (a_msb != b_msb) && (d_bit != a_msb);
        end
      end
    end
endmodule

// File: tb/tb_subtractor_serial.sv
// tb_subtractor_serial: directed and random checks of the serial subtractor against an arithmetic model
module tb_subtractor_serial;
  localparam int N = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, b_in = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic ready, b_out, overflow, zero, done;
  logic [N-1:0] diff;
  int n_assert = 0, n_fail = 0;

  subtractor_serial #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .a(a), .b(b), .b_in(b_in),
    .diff(diff), .b_out(b_out), .overflow(overflow), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_diff"}, diff, 0);
    chk({tag, "_b_out"}, b_out, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_zero"}, zero, 0);
  endtask

  // Reference: N+1-bit unsigned subtraction for diff/borrow, wide signed range check for overflow.
  task automatic model(input logic [N-1:0] av, bv, input logic bi,
                       output logic [N-1:0] ed, output logic eb, output logic eo);
    logic [N:0] full;
    longint s, lim;
    full = {1'b0, av} - {1'b0, bv} - (N+1)'(bi);
    ed = full[N-1:0];
    eb = full[N];
    lim = longint'(1) <<< (N - 1);
    s = longint'($signed(av)) - longint'($signed(bv)) - longint'(bi);
    eo = (s >= lim) || (s < -lim);
  endtask

  task automatic run_op(input logic [N-1:0] av, bv, input logic bi, input int mid, input int rst_at);
    logic [N-1:0] ed;
    logic eb, eo;
    int k;
    model(av, bv, bi, ed, eb, eo);
    @(negedge clk);
    chk("ready_before", ready, 1);
    a = av; b = bv; b_in = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; b_in = ~bi;
    chk("ready_busy", ready, 0);
    k = 0;
    while (k < N + 4) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        repeat (N + 3) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
        end
        rst = 1'b0;
        return;
      end
      if (done) break;
      if (k == mid) begin
        start = 1'b1; a = $urandom; b = $urandom; b_in = $urandom;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("latency", k, N);
    chk("diff", diff, ed);
    chk("b_out", b_out, eb);
    chk("overflow", overflow, eo);
    chk("zero", zero, ed == '0);
    @(negedge clk);
    chk("ready_after", ready, 1);
    chk("done_one_cycle", done, 0);
    chk("diff_hold", diff, ed);
    chk("b_out_hold", b_out, eb);
  endtask

  task automatic run_b2b(input logic [N-1:0] av, bv, input logic bi);
    logic [N-1:0] ed;
    logic eb, eo;
    int cyc;
    int t[$];
    model(av, bv, bi, ed, eb, eo);
    @(negedge clk);
    a = av; b = bv; b_in = bi; start = 1'b1;
    cyc = 0;
    while (cyc < 200 && t.size() < 3) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        t.push_back(cyc);
        chk("b2b_diff", diff, ed);
        chk("b2b_b_out", b_out, eb);
      end
    end
    start = 1'b0;
    chk("b2b_count", t.size(), 3);
    for (int i = 1; i < t.size(); i++) chk("b2b_gap", t[i] - t[i-1], N + 2);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle_after_reset");
    run_op(32'd5, 32'd3, 1'b0, -1, -1);
    run_op(32'd3, 32'd5, 1'b0, -1, -1);
    run_op(32'd7, 32'd7, 1'b0, -1, -1);
    run_op(32'h8000_0000, 32'd1, 1'b0, -1, -1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1);
    run_op(32'd0, 32'd0, 1'b1, -1, -1);
    run_op(32'h8000_0000, 32'd0, 1'b1, -1, -1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, -1);
    run_op(32'd100, 32'd42, 1'b0, 8, -1);
    run_b2b(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    run_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, -1, 10);
    run_op(32'd9, 32'd4, 1'b0, -1, -1);
    for (int i = 0; i < 20; i++) run_op($urandom, $urandom, 1'($urandom), -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/subtractor_serial.md
# subtractor_serial

Bit-serial N-bit subtractor computing `diff = a - b - b_in` one bit per clock, LSB first, through a single full-subtractor cell. It is the area-cheap inverse of the ripple-carry adder in the ALU datapath. It is used where subtraction or comparison latency is tolerable, such as multi-cycle compare/branch and divider prototypes. Operands enter through a start/ready handshake; the result is reported with a one-cycle `done` pulse plus borrow, signed-overflow and zero flags.

## Interface
- `N`, default 32: operand and result width (≥ 2).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a subtraction; accepted only while `ready`=1.
- `ready` output 1: high exactly when the block is in IDLE.
- `a` input N: minuend, sampled on the accept edge.
- `b` input N: subtrahend, sampled on the accept edge.
- `b_in` input 1: borrow-in, sampled on the accept edge.
- `diff` output N: result `a - b - b_in` mod 2^N.
- `b_out` output 1: unsigned borrow-out; 1 iff `a < b + b_in`.
- `overflow` output 1: signed overflow.
- `zero` output 1: 1 iff `diff`==0.
- `done` output 1: one-cycle pulse marking that the result is valid.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE → BUSY**
  - Taken on an edge with `start`=1.
  - Load `a`, `b` into shift registers, load `b_in` into the borrow flop, clear the bit counter.
- **BUSY, each edge**
  - The `subtractor_1` cell takes the LSBs of the `a` and `b` shift registers plus the borrow flop.
  - Its difference bit shifts into the MSB of the result register, which shifts right.
  - The borrow flop takes the cell's borrow-out; the counter increments.
  - On the edge where the counter reaches N-1 (the N-th processed bit), go to DONE.
- **DONE**
  - `done`=1 for exactly this cycle.
  - Go to IDLE on the next edge unconditionally.
- **Flags**
  - Computed from registered values, valid from DONE onward.
  - `b_out` = final borrow flop.
  - `overflow` = (a[N-1] ≠ b[N-1]) && (diff[N-1] ≠ a[N-1]), using the captured operand sign bits.
  - `zero` = (diff == 0).
- **Result hold**: `diff`, `b_out`, `overflow`, `zero` hold their last result through IDLE until the next accepted `start`. Between the accept edge and DONE they are undefined for consumers; the bench checks them only when `done`=1.
- **`start` in BUSY or DONE**: ignored; no queuing, no effect on the operation in flight.
- **Input changes**: `a`/`b`/`b_in` changing after the accept edge have no effect.
- **Reset**: asserted at any time, including mid-BUSY, it immediately forces IDLE and aborts the operation. No `done` pulse is produced for an aborted operation.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `diff`=0, `b_out`=0, `overflow`=0, `zero`=0, counter=0. (`zero` is forced 0 in reset even though `diff`=0; it becomes a computed flag only after the first DONE.)
- Accept edge E0. Bits 0..N-1 are processed on edges E1..EN, state=DONE after EN, `done` high between EN and EN+1, IDLE/`ready`=1 after EN+1.
- Latency: `done` rises N cycles after the accept edge. Throughput: one operation per N+2 cycles.
- Back-to-back: `start` held high re-accepts at the first edge with `ready`=1 (EN+1 is a DONE edge, so re-accept is at EN+2).
- `ready` is combinational from state; all other outputs are registered.

## Structure
- Package `subtractor_pkg`:
  - state enum `sub_state_t` {IDLE, BUSY, DONE};
  - counter width localparam `$clog2(N)`, passed as a parameter-derived width.
- Sub-module `subtractor_1`: combinational full subtractor with ports a, b, b_in, diff, b_out, where diff = a^b^b_in and b_out = (~a&b) | (~(a^b)&b_in). One instance only.

## Test plan
- a=5, b=3, b_in=0 → `done` exactly 32 cycles after accept; `diff`=2, `b_out`=0, `overflow`=0, `zero`=0.
- a=3, b=5 → `diff`=0xFFFFFFFE, `b_out`=1, `overflow`=0. Then a=7, b=7 → `diff`=0, `zero`=1, `b_out`=0.
- a=0x80000000, b=1 → `diff`=0x7FFFFFFF, `overflow`=1, `b_out`=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF → `diff`=0x80000000, `overflow`=1, `b_out`=1.
- a=0, b=0, b_in=1 → `diff`=0xFFFFFFFF, `b_out`=1, `zero`=0.
- `start` pulsed mid-BUSY with different operands → ignored, first result unchanged. `start` held high continuously → accepts every 34 cycles, with `done` pulses 34 cycles apart.
- `rst` asserted at bit 10 of an operation → `ready`=1 and all outputs at reset values immediately, no `done`. A fresh 9-4 afterward → `diff`=5.
